dot_update_queue: RTL and testbench

MMIO stage between the processor data-memory port and the VGA controller's dot-location write port. It decodes processor stores to the dot address window and queues them as X/Y updates in a FIFO. Queued updates are released only after the processor writes a commit marker, and then only during vertical blanking, so a whole generation appears on screen at once without tearing. It replaces the combinational dotWren/is_Yloc/dotID decode; the VGA controller consumes its outputs.

---
 rtl/dot_mmio_pkg.sv | 31 +++
 rtl/dot_update_queue_sync_fifo.sv | 57 +++++
 rtl/dot_update_queue.sv | 138 +++++++++++++
 tb/tb_dot_update_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dot_mmio_pkg.sv
// Shared constants and types for the dot-location MMIO stage between the CPU
// data port and the VGA dot-location write port.
package dot_mmio_pkg;

    localparam int unsigned DEPTH       = 64;
    localparam int unsigned ID_W        = 9;
    localparam int unsigned LOC_W       = 10;

    // Last address below the dot window.
    localparam int unsigned RNG         = 99;
    localparam int unsigned X_BASE      = 100;
    localparam int unsigned Y_BASE      = 550;
    localparam int unsigned WIN_END     = 999;
    localparam int unsigned COMMIT_ADDR = 1000;
    localparam int unsigned CLR_ADDR    = 1001;
    localparam int unsigned STAT_ADDR   = 1002;

    typedef struct packed {
        logic             is_y;
        logic [ID_W-1:0]  id;
        logic [LOC_W-1:0] loc;
    } dot_entry_t;

    localparam int unsigned ENTRY_W = $bits(dot_entry_t);

    typedef enum logic {
        IDLE,
        DRAIN
    } dot_state_e;

endpackage

// File: rtl/dot_update_queue_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pointers are exported so the owner
// can track a commit boundary inside the queue.
module sync_fifo #(
    parameter int unsigned Width = 20,
    parameter int unsigned Depth = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic [$clog2(Depth):0]   wr_ptr_o,
    output logic [$clog2(Depth):0]   rd_ptr_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_d, wr_ptr_q;
    logic [AW:0]      rd_ptr_d, rd_ptr_q;
    logic             do_push, do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_o;
        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_o  = wr_ptr_q - rd_ptr_q;
        rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_o = wr_ptr_q;
        rd_ptr_o = rd_ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/dot_update_queue.sv
// Decodes CPU stores into queued X/Y dot updates and releases each committed
// generation to the VGA controller only during vertical blanking.
module dot_update_queue
    import dot_mmio_pkg::*;
#(
    parameter int unsigned FifoDepth = DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wren,
    input  logic [31:0]      address_dmem,
    input  logic [31:0]      data,
    input  logic             vblank,
    output logic [31:0]      stat_data,
    output logic             dotWren,
    output logic             is_Yloc,
    output logic [ID_W-1:0]  dotID,
    output logic [LOC_W-1:0] dotLoc,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned PtrW = $clog2(FifoDepth) + 1;

    dot_state_e  state_d, state_q;
    dot_entry_t  push_entry, pop_entry;
    dot_entry_t  out_d, out_q;
    logic        wren_d, wren_q;
    logic        ovf_d, ovf_q;
    logic [31:0] stat_d, stat_q;
    logic [PtrW-1:0] commit_d, commit_q;
    logic [PtrW-1:0] wr_ptr, rd_ptr, count;
    logic        in_x, in_y, push_req, pop_req, fifo_full, fifo_empty;
    logic        drainable, last_pop;
    logic [31:0] off_x, off_y;
    logic        unused_bits;

    always_comb begin
        in_x     = (address_dmem >= 32'(X_BASE)) && (address_dmem < 32'(Y_BASE));
        in_y     = (address_dmem >= 32'(Y_BASE)) && (address_dmem <= 32'(WIN_END));
        push_req = wren && (in_x || in_y);
        off_x    = address_dmem - 32'(X_BASE);
        off_y    = address_dmem - 32'(Y_BASE);

        push_entry.is_y = in_y;
        push_entry.id   = in_y ? off_y[ID_W-1:0] : off_x[ID_W-1:0];
        push_entry.loc  = data[LOC_W-1:0];
    end

    assign unused_bits = ^{data[31:LOC_W], off_x[31:ID_W], off_y[31:ID_W], fifo_empty};

    sync_fifo #(
        .Width (ENTRY_W),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i    (clock),
        .rst_ni   (reset),
        .push_i   (push_req),
        .wdata_i  (push_entry),
        .pop_i    (pop_req),
        .rdata_o  (pop_entry),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (count),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr)
    );

    // Only entries strictly before the commit pointer may leave the queue.
    assign drainable = (rd_ptr != commit_q);
    assign last_pop  = ((rd_ptr + 1'b1) == commit_q);

    always_comb begin
        state_d = state_q;
        pop_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vblank && drainable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                pop_req = vblank && drainable;
                if (!vblank || !drainable || last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wren_d   = pop_req;
        out_d    = pop_req ? pop_entry : out_q;
        commit_d = (wren && address_dmem == 32'(COMMIT_ADDR)) ? wr_ptr : commit_q;

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (wren && address_dmem == 32'(CLR_ADDR)) begin
            ovf_d = 1'b0;
        end
        if (push_req && fifo_full && !pop_req) begin
            ovf_d = 1'b1;
        end

        stat_d = stat_q;
        if (address_dmem == 32'(STAT_ADDR)) begin
            stat_d = {ovf_q, 15'b0, 16'(count)};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wren_q   <= 1'b0;
            out_q    <= '0;
            commit_q <= '0;
            ovf_q    <= 1'b0;
            stat_q   <= '0;
        end else begin
            state_q  <= state_d;
            wren_q   <= wren_d;
            out_q    <= out_d;
            commit_q <= commit_d;
            ovf_q    <= ovf_d;
            stat_q   <= stat_d;
        end
    end

    assign dotWren   = wren_q;
    assign is_Yloc   = out_q.is_y;
    assign dotID     = out_q.id;
    assign dotLoc    = out_q.loc;
    assign full      = fifo_full;
    assign overflow  = ovf_q;
    assign stat_data = stat_q;

endmodule

// File: tb/tb_dot_update_queue.sv
// Directed bench for dot_update_queue: decode, commit gating, vblank draining,
// overflow handling and asynchronous reset.
module tb_dot_update_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        vblank;
    logic [31:0] stat_data;
    logic        dotWren;
    logic        is_Yloc;
    logic [8:0]  dotID;
    logic [9:0]  dotLoc;
    logic        full;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [19:0] obs_q[$];
    int          obs_cyc[$];

    dot_update_queue dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .address_dmem (address_dmem),
        .data         (data),
        .vblank       (vblank),
        .stat_data    (stat_data),
        .dotWren      (dotWren),
        .is_Yloc      (is_Yloc),
        .dotID        (dotID),
        .dotLoc       (dotLoc),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (dotWren === 1'b1) begin
            obs_q.push_back({is_Yloc, dotID, dotLoc});
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [19:0] pack(input logic y, input int id, input int loc);
        logic [8:0] i9;
        logic [9:0] l10;
        i9  = id[8:0];
        l10 = loc[9:0];
        return {y, i9, l10};
    endfunction

    function automatic logic [19:0] get_obs(input int i);
        if (i < obs_q.size()) return obs_q[i];
        return 20'hFFFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        wren = 1'b1;
        address_dmem = a;
        data = d;
        @(negedge clock);
        wren = 1'b0;
        address_dmem = '0;
        data = '0;
    endtask

    task automatic read_stat();
        address_dmem = 32'd1002;
        @(negedge clock);
        address_dmem = '0;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        int nerr;
        reset = 1'b0;
        wren = 1'b0;
        address_dmem = '0;
        data = '0;
        vblank = 1'b0;
        #1;
        check("rst_wren", {31'b0, dotWren}, 32'd0);
        check("rst_fields", {12'b0, is_Yloc, dotID, dotLoc}, 32'd0);
        check("rst_stat", stat_data, 32'd0);
        check("rst_flags", {30'b0, full, overflow}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(1);

        // X and Y stores, commit, one vblank window
        clear_obs();
        store(32'd100, 32'd37);
        store(32'd550, 32'd52);
        store(32'd1000, 32'd0);
        vblank = 1'b1;
        idle(5);
        vblank = 1'b0;
        idle(3);
        check("t1_nstrobe", obs_q.size(), 32'd2);
        check("t1_first", {12'b0, get_obs(0)}, {12'b0, pack(1'b0, 0, 37)});
        check("t1_second", {12'b0, get_obs(1)}, {12'b0, pack(1'b1, 0, 52)});
        if (obs_cyc.size() == 2) check("t1_consec", obs_cyc[1] - obs_cyc[0], 32'd1);
        else check("t1_consec", obs_cyc.size(), 32'd2);

        // Uncommitted store is held back across vblank
        clear_obs();
        store(32'd999, 32'hFFFF_F123);
        vblank = 1'b1;
        idle(10);
        vblank = 1'b0;
        idle(2);
        check("t2_held", obs_q.size(), 32'd0);
        store(32'd1000, 32'd0);
        vblank = 1'b1;
        idle(4);
        vblank = 1'b0;
        idle(2);
        check("t2_nstrobe", obs_q.size(), 32'd1);
        check("t2_entry", {12'b0, get_obs(0)}, {12'b0, pack(1'b1, 449, 32'h123)});
        check("t2_hold", {21'b0, dotWren, is_Yloc, dotID}, {21'b0, 1'b0, 1'b1, 9'd449});

        // Fill, overflow, commit, status, clear
        for (int i = 0; i < 64; i++) store(32'(100 + i), 32'(i));
        store(32'd164, 32'd64);
        store(32'd1000, 32'd0);
        check("t3_full", {31'b0, full}, 32'd1);
        check("t3_ovf", {31'b0, overflow}, 32'd1);
        read_stat();
        check("t3_stat", stat_data, 32'h8000_0040);
        store(32'd1001, 32'd0);
        check("t3_ovf_clr", {31'b0, overflow}, 32'd0);

        // Push alongside a pop while full
        clear_obs();
        vblank = 1'b1;
        idle(1);
        wren = 1'b1;
        address_dmem = 32'd200;
        data = 32'd777;
        idle(1);
        wren = 1'b0;
        vblank = 1'b0;
        address_dmem = 32'd1002;
        idle(1);
        address_dmem = '0;
        check("t5_stat", stat_data, 32'h0000_0040);
        check("t5_full", {31'b0, full}, 32'd1);
        check("t5_no_ovf", {31'b0, overflow}, 32'd0);
        store(32'd1000, 32'd0);
        vblank = 1'b1;
        idle(70);
        vblank = 1'b0;
        idle(3);
        check("t5_nstrobe", obs_q.size(), 32'd65);
        nerr = 0;
        for (int i = 0; i < 64; i++) if (get_obs(i) !== pack(1'b0, i, i)) nerr++;
        check("t5_order", nerr, 32'd0);
        check("t5_last", {12'b0, get_obs(64)}, {12'b0, pack(1'b0, 100, 777)});
        check("t5_empty", {31'b0, full}, 32'd0);

        // vblank drops mid-drain, remainder follows next vblank
        clear_obs();
        for (int i = 0; i < 20; i++) store(32'(100 + i), 32'(500 + i));
        store(32'd1000, 32'd0);
        vblank = 1'b1;
        idle(6);
        vblank = 1'b0;
        idle(5);
        check("t4_partial", obs_q.size(), 32'd5);
        vblank = 1'b1;
        idle(30);
        vblank = 1'b0;
        idle(3);
        check("t4_total", obs_q.size(), 32'd20);
        nerr = 0;
        for (int i = 0; i < 20; i++) if (get_obs(i) !== pack(1'b0, i, 500 + i)) nerr++;
        check("t4_order", nerr, 32'd0);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 10; i++) store(32'(560 + i), 32'(i + 1));
        store(32'd1000, 32'd0);
        vblank = 1'b1;
        idle(3);
        check("t6_mid", {31'b0, dotWren}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6_async", {31'b0, dotWren}, 32'd0);
        check("t6_fields", {12'b0, is_Yloc, dotID, dotLoc}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        vblank = 1'b0;
        idle(1);
        clear_obs();
        read_stat();
        check("t6_stat", stat_data, 32'd0);
        vblank = 1'b1;
        idle(20);
        vblank = 1'b0;
        idle(2);
        check("t6_quiet", obs_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
